// File: rtl/lock_pkg.sv
// ============================================================================
// lock_pkg : shared keypad geometry, scan FSM states and helpers. Rev 1.0
// ============================================================================
`default_nettype none

package lock_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam logic [KEY_ROWS-1:0] ROW_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Index of the lowest zero bit of an active-low vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_scan_tick_gen.sv
// ============================================================================
// tick_gen : free-running one-clk strobe every DIV clocks. Rev 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int DIV = 6250
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_scan.sv
// ============================================================================
// key_scan : 4x4 matrix keypad scanner with press/release debounce. Rev 1.0
// ============================================================================
`default_nettype none

module key_scan
  import lock_pkg::*;
#(
  parameter int SCAN_DIV  = 6250,
  parameter int DEB_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_COLS-1:0] col,
  output logic [KEY_ROWS-1:0] row,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_TICKS);

  logic tick;

  state_e              state_q, state_d;
  logic [KEY_ROWS-1:0] row_q, row_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [3:0]          key_code_q, key_code_d;
  logic [KEY_COLS-1:0] sync1_q, col_s_q;

  tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      col_s_q <= '1;
    end else begin
      sync1_q <= col;
      col_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      row_q      <= ROW_RESET;
      col_idx_q  <= 2'd0;
      cnt_q      <= '0;
      key_code_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_idx_q  <= col_idx_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
    end
  end

  // Saturating increment keeps the counter pinned at DEB_TICKS.
  assign cnt_inc = (cnt_q >= DEB_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_idx_d  = col_idx_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (col_s_q == '1) begin
            row_d = {row_q[KEY_ROWS-2:0], row_q[KEY_ROWS-1]};
          end else begin
            col_idx_d = low_index(col_s_q);
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!col_s_q[col_idx_q]) begin
            cnt_d = cnt_inc;
            // Load the code on entry so it is already valid during the strobe.
            if (cnt_inc == DEB_MAX) begin
              state_d    = PRESSED;
              key_code_d = {low_index(row_q), col_idx_q};
            end
          end else begin
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
      end
      PRESSED: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (tick) begin
          if (col_s_q == '1) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_MAX) begin
              cnt_d   = '0;
              state_d = SCAN;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_comb begin
    row       = row_q;
    key_code  = key_code_q;
    key_valid = (state_q == PRESSED);
    key_held  = (state_q == PRESSED) || (state_q == RELEASE);
  end

endmodule

`default_nettype wire
